// File: rtl/mcycle_pkg.sv
// mcycle_pkg: op encodings and FSM state type shared by the mcycle_unit slice.
package mcycle_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FIXUP,
        DONE
    } mcycleState_t;

    function automatic logic isDivOp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mcycle_signfix.sv
// mcycle_signfix: conditional two's-complement negate, used for operand
// magnitudes and for the result sign correction.
module mcycle_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = value;
        if (negate) begin
            result = (~value) + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: multi-cycle shift-add multiply / restoring divide for the Execute stage.
// Define MCYCLE_SIGNED_EN to add the signed ops and the FIXUP sign-correction state.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             Flush,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ITER_MAX  = CW'(WIDTH);

    mcycleState_t state, nextState;

    logic [CW-1:0]      iterCnt;
    logic               opDiv;
    logic [WIDTH-1:0]   opB;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     remReg;

    logic               idleLike;
    logic               accept;
    logic               divZero;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH+1:0]   divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] iterAcc;
    logic [WIDTH:0]     iterRem;

    // DONE accepts a new Start exactly like IDLE, so back-to-back ops lose no cycle
    assign idleLike = (state == IDLE) || (state == DONE);
    assign accept   = idleLike && Start && !Flush;
    assign divZero  = isDivOp(MCycleOp) && (Operand2 == '0);

`ifdef MCYCLE_SIGNED_EN
    logic               sign1;
    logic               sign2;
    logic               resSign;
    logic               remSign;
    logic [2*WIDTH-1:0] fixProd;
    logic [WIDTH-1:0]   fixQuot;
    logic [WIDTH-1:0]   fixRem;

    assign sign1 = MCycleOp[0] & Operand1[WIDTH-1];
    assign sign2 = MCycleOp[0] & Operand2[WIDTH-1];

    mcycle_signfix #(.WIDTH(WIDTH)) uMag1 (
        .value (Operand1),
        .negate(sign1),
        .result(mag1)
    );

    mcycle_signfix #(.WIDTH(WIDTH)) uMag2 (
        .value (Operand2),
        .negate(sign2),
        .result(mag2)
    );

    mcycle_signfix #(.WIDTH(2 * WIDTH)) uFixProd (
        .value (acc),
        .negate(resSign),
        .result(fixProd)
    );

    mcycle_signfix #(.WIDTH(WIDTH)) uFixQuot (
        .value (acc[WIDTH-1:0]),
        .negate(resSign),
        .result(fixQuot)
    );

    mcycle_signfix #(.WIDTH(WIDTH)) uFixRem (
        .value (remReg[WIDTH-1:0]),
        .negate(remSign),
        .result(fixRem)
    );
`else
    logic unusedOpSign;

    assign unusedOpSign = MCycleOp[0];
    assign mag1         = Operand1;
    assign mag2         = Operand2;
`endif

    // acc[WIDTH-1:0] holds the multiplier (MUL) or the dividend shifting into the quotient (DIV)
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        divShift = {remReg[WIDTH-1:0], acc[WIDTH-1]};
        divDiff  = {1'b0, divShift} - {2'b00, opB};
        divFits  = ~divDiff[WIDTH+1];
        iterAcc  = {mulSum, acc[WIDTH-1:1]};
        iterRem  = remReg;
        if (opDiv) begin
            iterAcc = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], divFits};
            iterRem = divFits ? divDiff[WIDTH:0] : divShift;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                nextState = IDLE;
                if (accept) begin
                    nextState = divZero ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                if (Flush) begin
                    nextState = IDLE;
                end else if (iterCnt == ITER_LAST) begin
`ifdef MCYCLE_SIGNED_EN
                    nextState = FIXUP;
`else
                    nextState = DONE;
`endif
                end
            end
            FIXUP: begin
                nextState = Flush ? IDLE : DONE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= nextState;
            Busy  <= (nextState == COMPUTE) || (nextState == FIXUP);
            Done  <= (nextState == DONE);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            iterCnt   <= '0;
            opDiv     <= 1'b0;
            opB       <= '0;
            acc       <= '0;
            remReg    <= '0;
            Result1   <= '0;
            Result2   <= '0;
            DivByZero <= 1'b0;
`ifdef MCYCLE_SIGNED_EN
            resSign   <= 1'b0;
            remSign   <= 1'b0;
`endif
        end else if (accept) begin
            iterCnt <= '0;
            opDiv   <= isDivOp(MCycleOp);
            remReg  <= '0;
            if (divZero) begin
                Result1   <= '1;
                Result2   <= Operand1;
                DivByZero <= 1'b1;
            end else begin
                DivByZero <= 1'b0;
                acc       <= {{WIDTH{1'b0}}, isDivOp(MCycleOp) ? mag1 : mag2};
                opB       <= isDivOp(MCycleOp) ? mag2 : mag1;
`ifdef MCYCLE_SIGNED_EN
                resSign   <= sign1 ^ sign2;
                remSign   <= sign1;
`endif
            end
        end else if (state == COMPUTE) begin
            acc    <= iterAcc;
            remReg <= iterRem;
            if (iterCnt != ITER_MAX) begin
                iterCnt <= iterCnt + CW'(1);
            end
`ifndef MCYCLE_SIGNED_EN
            // without FIXUP the last iteration's value goes straight to the outputs
            if ((iterCnt == ITER_LAST) && !Flush) begin
                Result1 <= iterAcc[WIDTH-1:0];
                Result2 <= opDiv ? iterRem[WIDTH-1:0] : iterAcc[2*WIDTH-1:WIDTH];
            end
`endif
        end
`ifdef MCYCLE_SIGNED_EN
        else if ((state == FIXUP) && !Flush) begin
            Result1 <= opDiv ? fixQuot : fixProd[WIDTH-1:0];
            Result2 <= opDiv ? fixRem  : fixProd[2*WIDTH-1:WIDTH];
        end
`endif
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed and randomized checks of mcycle_unit against an arithmetic reference model.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int WIDTH = 32;
`ifdef MCYCLE_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
    localparam int LAT       = WIDTH + 2;
`else
    localparam bit SIGNED_EN = 1'b0;
    localparam int LAT       = WIDTH + 1;
`endif

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic        Flush;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;
    logic        Done;
    logic        DivByZero;

    int          nCompared = 0;
    int          nMismatch = 0;
    logic [31:0] lastR1    = '0;
    logic [31:0] lastR2    = '0;

    mcycle_unit #(.WIDTH(WIDTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .Flush    (Flush),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done),
        .DivByZero(DivByZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned 64-bit arithmetic, truncating division
    function automatic void refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r1, output logic [31:0] r2, output logic dz);
        longint      sa;
        longint      sb;
        logic [63:0] bits;
        bit          sgn;
        sgn  = SIGNED_EN && op[0];
        sa   = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb   = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        dz   = 1'b0;
        if (!op[1]) begin
            bits = 64'(sa * sb);
            r1   = bits[31:0];
            r2   = bits[63:32];
        end else if (b == 32'd0) begin
            r1 = '1;
            r2 = a;
            dz = 1'b1;
        end else begin
            bits = 64'(sa / sb);
            r1   = bits[31:0];
            bits = 64'(sa % sb);
            r2   = bits[31:0];
        end
    endfunction

    // b2b=1 raises Start in the current (Done) cycle instead of waiting one cycle
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit b2b);
        logic [31:0] e1;
        logic [31:0] e2;
        logic        edz;
        int          expL;
        int          cyc;
        int          busyCnt;
        int          doneCyc;
        logic        busyAtDone;
        refModel(op, a, b, e1, e2, edz);
        expL = edz ? 1 : LAT;
        if (!b2b) @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        @(negedge CLK);
        Start      = 1'b0;
        cyc        = 1;
        busyCnt    = 0;
        doneCyc    = 0;
        busyAtDone = 1'b0;
        while (doneCyc == 0 && cyc <= LAT + 4) begin
            if (Done === 1'b1) begin
                doneCyc    = cyc;
                busyAtDone = Busy;
            end else begin
                if (Busy === 1'b1) busyCnt++;
                @(negedge CLK);
                cyc++;
            end
        end
        checkVal({tag, " doneCycle"}, 64'(doneCyc), 64'(expL));
        checkVal({tag, " busyCycles"}, 64'(busyCnt), 64'(expL - 1));
        checkVal({tag, " busyAtDone"}, 64'(busyAtDone), 64'd0);
        checkVal({tag, " Result1"}, 64'(Result1), 64'(e1));
        checkVal({tag, " Result2"}, 64'(Result2), 64'(e2));
        checkVal({tag, " DivByZero"}, 64'(DivByZero), 64'(edz));
        lastR1 = e1;
        lastR2 = e2;
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic doneSeen;
        RESET    = 1'b0;
        Start    = 1'b0;
        Flush    = 1'b0;
        MCycleOp = OP_MULU;
        Operand1 = '0;
        Operand2 = '0;
        #22;
        checkVal("reset Result1", 64'(Result1), 64'd0);
        checkVal("reset Result2", 64'(Result2), 64'd0);
        checkVal("reset Busy", 64'(Busy), 64'd0);
        checkVal("reset Done", 64'(Done), 64'd0);
        checkVal("reset DivByZero", 64'(DivByZero), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        runOp("mulu max", OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("muls -3x7", OP_MULS, 32'hFFFF_FFFD, 32'd7, 1'b0);
        runOp("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        runOp("divs -7/2", OP_DIVS, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runOp("divs min/-1", OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp("divu 5/0", OP_DIVU, 32'd5, 32'd0, 1'b0);
        runOp("divs b2b /0", OP_DIVS, 32'h8000_0001, 32'd0, 1'b1);
        runOp("muls b2b", OP_MULS, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        runOp("divu b2b", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b1);

        // Flush in cycle 10 of a MUL, then re-issue in cycle 12
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = OP_MULU;
        Operand1 = 32'h0001_2345;
        Operand2 = 32'h0006_789A;
        doneSeen = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            Start = 1'b0;
            if (Done === 1'b1) doneSeen = 1'b1;
            if (c == 10) begin
                checkVal("flush busyBefore", 64'(Busy), 64'd1);
                Flush = 1'b1;
            end
            if (c == 11) begin
                Flush = 1'b0;
                checkVal("flush busyAfter", 64'(Busy), 64'd0);
            end
        end
        checkVal("flush noDone", 64'(doneSeen), 64'd0);
        checkVal("flush Result1 held", 64'(Result1), 64'(lastR1));
        checkVal("flush Result2 held", 64'(Result2), 64'(lastR2));
        runOp("flush reissue", OP_MULU, 32'h0001_2345, 32'h0006_789A, 1'b0);

        // Start together with Flush in IDLE must be dropped
        for (int t = 0; t < 2; t++) begin
            @(negedge CLK);
            Start    = 1'b1;
            Flush    = 1'b1;
            MCycleOp = (t == 0) ? OP_DIVU : OP_MULU;
            Operand1 = 32'd9;
            Operand2 = (t == 0) ? 32'd0 : 32'd3;
            @(negedge CLK);
            Start = 1'b0;
            Flush = 1'b0;
            checkVal("startFlush Busy", 64'(Busy), 64'd0);
            checkVal("startFlush Done", 64'(Done), 64'd0);
            checkVal("startFlush Result1", 64'(Result1), 64'(lastR1));
        end

        for (int i = 0; i < 40; i++) begin
            runOp($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), randOperand(), randOperand(),
                  bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset in cycle 20 of an operation
        runOp("pre-reset div0", OP_DIVU, 32'd77, 32'd0, 1'b0);
        @(negedge CLK);
        Start    = 1'b1;
        MCycleOp = OP_MULU;
        Operand1 = 32'd3;
        Operand2 = 32'd5;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            Start = 1'b0;
        end
        checkVal("midop Busy", 64'(Busy), 64'd1);
        RESET = 1'b0;
        #1;
        checkVal("asyncReset Busy", 64'(Busy), 64'd0);
        checkVal("asyncReset Done", 64'(Done), 64'd0);
        checkVal("asyncReset Result1", 64'(Result1), 64'd0);
        checkVal("asyncReset Result2", 64'(Result2), 64'd0);
        checkVal("asyncReset DivByZero", 64'(DivByZero), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        runOp("post-reset 6x7", OP_MULU, 32'd6, 32'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
